conv_window_buffer: RTL and testbench

Sliding-window sample buffer that sits directly upstream of the convolution stage. Accepts one multi-channel glove sample per handshake, keeps the most recent DEPTH samples as a DEPTH×CHANNELS window, and launches a convolution with a one-cycle start pulse whenever a full window with HOP new samples is available. The window is frozen while the convolution runs and released on the convolution's finished pulse.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_window_buffer.sv | 157 +++++++++++++++
 tb/tb_conv_window_buffer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front end: default window geometry,
// the row-stride helper and the window buffer state type.
package conv_pkg;

    localparam int CONV_CHANNELS = 5;
    localparam int CONV_DEPTH    = 8;
    localparam int CONV_WIDTH    = 16;

    // Flat window layout: element (row, channel) lives at row*ROW_STRIDE + channel.
    localparam int ROW_STRIDE = CONV_CHANNELS;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2
    } conv_state_e;

    function automatic int winIndex(input int row, input int channel, input int stride);
        return row * stride + channel;
    endfunction

endpackage

// File: rtl/conv_window_buffer.sv
// Sliding DEPTHxCHANNELS sample window feeding the convolution stage; freezes while a
// convolution runs. Optional drop counter is built when CONVWIN_DROP_CNT_EN is defined.
module conv_window_buffer
    import conv_pkg::*;
#(
    parameter int CHANNELS = CONV_CHANNELS,
    parameter int DEPTH    = CONV_DEPTH,
    parameter int WIDTH    = CONV_WIDTH,
    parameter int HOP      = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_sample [0:CHANNELS-1],
    output logic             o_ready,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data [0:DEPTH*CHANNELS-1],
    output logic             o_start,
    input  logic             i_conv_done,
    output logic [7:0]       o_drop_cnt
);

    localparam int CW    = $clog2(DEPTH + 1);
    localparam int ELEMS = DEPTH * CHANNELS;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] HOP_C   = CW'(HOP);

    conv_state_e state_q, state_d;

    logic [WIDTH-1:0] window_q [0:ELEMS-1];
    logic [WIDTH-1:0] window_d [0:ELEMS-1];
    logic [CW-1:0]    fill_q, fill_d;
    logic [CW-1:0]    hop_q, hop_d;
    logic             flushPend_q, flushPend_d;

    logic             accept;
    logic             launch;
    logic             releaseFlush;
    logic [CW-1:0]    fillInc;
    logic [CW-1:0]    hopInc;

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (launch)      state_d = S_LAUNCH;
            S_LAUNCH:                   state_d = S_WAIT;
            S_WAIT:    if (i_conv_done) state_d = S_COLLECT;
            default:                    state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        o_ready = (state_q == S_COLLECT);
        o_start = (state_q == S_LAUNCH);
    end

    // Both counters saturate at DEPTH; hop never needs more since HOP <= DEPTH.
    always_comb begin
        fillInc      = (fill_q == DEPTH_C) ? fill_q : fill_q + CW'(1);
        hopInc       = (hop_q  == DEPTH_C) ? hop_q  : hop_q  + CW'(1);
        accept       = i_valid && o_ready && !i_flush;
        launch       = accept && (fillInc == DEPTH_C) && (hopInc >= HOP_C);
        releaseFlush = (state_q == S_WAIT) && i_conv_done && (flushPend_q || i_flush);
    end

    always_comb begin
        window_d    = window_q;
        fill_d      = fill_q;
        hop_d       = hop_q;
        flushPend_d = flushPend_q;

        if ((state_q == S_COLLECT) && i_flush) begin
            for (int i = 0; i < ELEMS; i++) begin
                window_d[i] = '0;
            end
            fill_d = '0;
            hop_d  = '0;
        end else if (accept) begin
            for (int r = 0; r < DEPTH - 1; r++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    window_d[winIndex(r, c, CHANNELS)] = window_q[winIndex(r + 1, c, CHANNELS)];
                end
            end
            for (int c = 0; c < CHANNELS; c++) begin
                window_d[winIndex(DEPTH - 1, c, CHANNELS)] = i_sample[c];
            end
            fill_d = fillInc;
            hop_d  = launch ? '0 : hopInc;
        end

        if ((state_q != S_COLLECT) && i_flush) begin
            flushPend_d = 1'b1;
        end

        // A deferred flush lands only once the running convolution has released the window.
        if (releaseFlush) begin
            for (int i = 0; i < ELEMS; i++) begin
                window_d[i] = '0;
            end
            fill_d      = '0;
            hop_d       = '0;
            flushPend_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            for (int i = 0; i < ELEMS; i++) begin
                window_q[i] <= '0;
            end
            fill_q      <= '0;
            hop_q       <= '0;
            flushPend_q <= 1'b0;
        end else begin
            for (int i = 0; i < ELEMS; i++) begin
                window_q[i] <= window_d[i];
            end
            fill_q      <= fill_d;
            hop_q       <= hop_d;
            flushPend_q <= flushPend_d;
        end
    end

    assign o_data = window_q;

`ifdef CONVWIN_DROP_CNT_EN
    logic [7:0] dropCnt_q, dropCnt_d;

    always_comb begin
        dropCnt_d = dropCnt_q;
        if (i_valid && !o_ready && !i_flush && (dropCnt_q != 8'hFF)) begin
            dropCnt_d = dropCnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            dropCnt_q <= '0;
        end else begin
            dropCnt_q <= dropCnt_d;
        end
    end

    assign o_drop_cnt = dropCnt_q;
`else
    assign o_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer: a HOP=1 instance for the main scenarios and a
// HOP=4 instance for hop spacing and drop-counter saturation.
module tb_conv_window_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic        done  = 1'b0;
    logic [15:0] sample [0:4];
    logic [15:0] data   [0:39];
    logic        ready;
    logic        start;
    logic [7:0]  drop;

    logic        valid4 = 1'b0;
    logic        flush4 = 1'b0;
    logic        done4  = 1'b0;
    logic [15:0] sample4 [0:4];
    logic [15:0] data4   [0:39];
    logic        ready4;
    logic        start4;
    logic [7:0]  drop4;

    int checks = 0;
    int errors = 0;

`ifdef CONVWIN_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    conv_window_buffer #(.CHANNELS(5), .DEPTH(8), .WIDTH(16), .HOP(1)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_valid     (valid),
        .i_sample    (sample),
        .o_ready     (ready),
        .i_flush     (flush),
        .o_data      (data),
        .o_start     (start),
        .i_conv_done (done),
        .o_drop_cnt  (drop)
    );

    conv_window_buffer #(.CHANNELS(5), .DEPTH(8), .WIDTH(16), .HOP(4)) dut4 (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_valid     (valid4),
        .i_sample    (sample4),
        .o_ready     (ready4),
        .i_flush     (flush4),
        .o_data      (data4),
        .o_start     (start4),
        .i_conv_done (done4),
        .o_drop_cnt  (drop4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock on the HOP=1 instance; inputs held across the edge, outputs settled after it.
    task automatic applyStimulus(input logic v, input int k, input logic f, input logic d);
        valid = v;
        flush = f;
        done  = d;
        for (int c = 0; c < 5; c++) sample[c] = 16'(k * 16 + c);
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
        done  = 1'b0;
    endtask

    task automatic applyStimulusHop(input logic v, input int k, input logic d);
        valid4 = v;
        done4  = d;
        for (int c = 0; c < 5; c++) sample4[c] = 16'(k * 16 + c);
        @(posedge clk);
        #1;
        valid4 = 1'b0;
        done4  = 1'b0;
    endtask

    function automatic int countNonZero();
        int n = 0;
        for (int i = 0; i < 40; i++) if (data[i] !== 16'h0) n++;
        return n;
    endfunction

    // Window expected to hold samples firstK..firstK+7, oldest in row 0.
    function automatic int countRampErrors(input int firstK);
        int n = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (data[r * 5 + c] !== 16'((firstK + r) * 16 + c)) n++;
        return n;
    endfunction

    initial begin
        int startsSeen;
        for (int c = 0; c < 5; c++) begin
            sample[c]  = '0;
            sample4[c] = '0;
        end

        // Reset state
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        rst = 1'b0;
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_start", start, 0);
        checkOutput("reset_drop", drop, 0);
        checkOutput("reset_window_zero", countNonZero(), 0);

        // First fill: launch only after the 8th accept
        startsSeen = 0;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1, k, 0, 0);
            if (start) startsSeen++;
        end
        checkOutput("fill_no_early_start", startsSeen, 0);
        checkOutput("fill_ready_before_8th", ready, 1);
        applyStimulus(1, 7, 0, 0);
        checkOutput("launch1_start", start, 1);
        checkOutput("launch1_ready", ready, 0);
        checkOutput("launch1_data0", data[0], 16'h0000);
        checkOutput("launch1_data39", data[39], 16'h0074);
        checkOutput("launch1_ramp", countRampErrors(0), 0);

        applyStimulus(0, 0, 0, 0);
        checkOutput("wait_start_one_cycle", start, 0);
        checkOutput("wait_ready", ready, 0);

        // Offered samples during WAIT are dropped and leave the window alone
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 99, 0, 0);
            checkOutput("drop_ready_low", ready, 0);
        end
        checkOutput("drop_window_frozen", countRampErrors(0), 0);
        checkOutput("drop_count3", drop, DROP_EN ? 3 : 0);

        // Convolution finishes 4 cycles after the start pulse
        applyStimulus(0, 0, 0, 1);
        checkOutput("done_ready", ready, 1);
        checkOutput("done_start", start, 0);
        applyStimulus(1, 8, 0, 0);
        checkOutput("launch2_start", start, 1);
        checkOutput("launch2_data0", data[0], 16'h0010);
        checkOutput("launch2_data35", data[35], 16'h0080);
        checkOutput("launch2_ramp", countRampErrors(1), 0);

        // Flush during WAIT is deferred until the convolution releases the window
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("flushwait_window_stable", data[0], 16'h0010);
        checkOutput("flushwait_ready", ready, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("flushwait_ready_after_done", ready, 1);
        checkOutput("flushwait_window_zero", countNonZero(), 0);
        startsSeen = 0;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1, k, 0, 0);
            if (start) startsSeen++;
        end
        checkOutput("flushwait_no_early_start", startsSeen, 0);
        applyStimulus(1, 7, 0, 0);
        checkOutput("flushwait_launch", start, 1);
        checkOutput("flushwait_ramp", countRampErrors(0), 0);

        // Reset while waiting abandons the launch; stray done is ignored
        applyStimulus(0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1);
        checkOutput("rstwait_ready", ready, 1);
        checkOutput("rstwait_start", start, 0);
        checkOutput("rstwait_window_zero", countNonZero(), 0);
        checkOutput("rstwait_drop", drop, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rstwait_start_later", start, 0);

        // Flush in COLLECT beats a simultaneous valid and restarts the fill
        for (int k = 0; k < 3; k++) applyStimulus(1, k, 0, 0);
        checkOutput("partial_fill_row7", data[35], 16'h0020);
        applyStimulus(1, 3, 1, 0);
        checkOutput("flushcol_window_zero", countNonZero(), 0);
        checkOutput("flushcol_ready", ready, 1);
        checkOutput("flushcol_no_drop", drop, 0);
        startsSeen = 0;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1, k, 0, 0);
            if (start) startsSeen++;
        end
        checkOutput("flushcol_no_early_start", startsSeen, 0);
        applyStimulus(1, 7, 0, 0);
        checkOutput("flushcol_launch", start, 1);

        // HOP=4: first launch after 8 accepts, then every 4 accepts
        startsSeen = 0;
        for (int k = 0; k < 7; k++) begin
            applyStimulusHop(1, k, 0);
            if (start4) startsSeen++;
        end
        checkOutput("hop4_no_early_start", startsSeen, 0);
        applyStimulusHop(1, 7, 0);
        checkOutput("hop4_launch1", start4, 1);
        applyStimulusHop(0, 0, 0);
        applyStimulusHop(0, 0, 1);
        checkOutput("hop4_ready_after_done", ready4, 1);
        startsSeen = 0;
        for (int k = 8; k < 11; k++) begin
            applyStimulusHop(1, k, 0);
            if (start4) startsSeen++;
        end
        checkOutput("hop4_no_start_3_accepts", startsSeen, 0);
        applyStimulusHop(1, 11, 0);
        checkOutput("hop4_launch2", start4, 1);
        checkOutput("hop4_data0", data4[0], 16'h0040);
        checkOutput("hop4_data39", data4[39], 16'h00B4);
        checkOutput("hop4_drop_before", drop4, 0);

        // 300 offered samples while frozen saturate the drop counter
        applyStimulusHop(0, 0, 0);
        for (int i = 0; i < 300; i++) applyStimulusHop(1, 200, 0);
        checkOutput("hop4_drop_saturate", drop4, DROP_EN ? 255 : 0);
        checkOutput("hop4_window_frozen", data4[0], 16'h0040);
        applyStimulusHop(0, 0, 1);
        checkOutput("hop4_release_ready", ready4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
